// File: rtl/c432_bist_pkg.sv
// ============================================================================
//  Module   : c432_bist_pkg
//  Brief    : Shared types and constants for the c432 BIST controller.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package c432_bist_pkg;

    localparam int PI_W  = 36;
    localparam int PO_W  = 7;
    localparam int SIG_W = 16;

    localparam int LFSR_TAP_HI = 35;
    localparam int LFSR_TAP_LO = 24;

    localparam logic [SIG_W-1:0] MISR_POLY = 16'h1021;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SEED    = 3'd1,
        ST_APPLY   = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    // Fibonacci step for x^36 + x^25 + 1
    function automatic logic [PI_W-1:0] lfsr_next(input logic [PI_W-1:0] v);
        return {v[PI_W-2:0], v[LFSR_TAP_HI] ^ v[LFSR_TAP_LO]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/c432_bist_if.sv
// ============================================================================
//  Module   : c432_bist_if
//  Brief    : Test-access and CUT-facing signal bundle of the c432 BIST block.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface c432_bist_if;
    import c432_bist_pkg::*;

    logic              start;
    logic [PI_W-1:0]   cut_pi;
    logic [PO_W-1:0]   cut_po;
    logic              busy;
    logic              done;
    logic              pass;
    logic [SIG_W-1:0]  signature;
    logic [15:0]       pat_count;

    modport master (
        output start, cut_po,
        input  cut_pi, busy, done, pass, signature, pat_count
    );

    modport slave (
        input  start, cut_po,
        output cut_pi, busy, done, pass, signature, pat_count
    );

endinterface

`default_nettype wire

// File: rtl/c432_bist_misr.sv
// ============================================================================
//  Module   : c432_bist_misr
//  Brief    : 16-bit MISR compacting the 7 c432 primary outputs.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module c432_bist_misr
    import c432_bist_pkg::*;
(
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              clear,
    input  wire logic              enable,
    input  wire logic [PO_W-1:0]   data,
    output logic      [SIG_W-1:0]  signature
);

    logic [SIG_W-1:0] r_sig;
    logic [SIG_W-1:0] w_next;

    always_comb begin
        w_next = {r_sig[SIG_W-2:0], 1'b0}
               ^ (r_sig[SIG_W-1] ? MISR_POLY : {SIG_W{1'b0}})
               ^ {{(SIG_W-PO_W){1'b0}}, data};
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_sig <= '0;
        end else if (enable) begin
            r_sig <= w_next;
        end
    end

    assign signature = r_sig;

endmodule

`default_nettype wire

// File: rtl/c432_bist_ctrl.sv
// ============================================================================
//  Module   : c432_bist_ctrl
//  Brief    : LFSR pattern source, settle timer and MISR check for the c432 CUT.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module c432_bist_ctrl
    import c432_bist_pkg::*;
#(
    parameter int               N_PATTERNS    = 256,
    parameter int               SETTLE_CYCLES = 1,
    parameter logic [PI_W-1:0]  LFSR_SEED     = 36'h0_0000_0001,
    parameter logic [SIG_W-1:0] GOLDEN_SIG    = 16'h0000
)(
    input  wire logic    clk,
    input  wire logic    rst,
    c432_bist_if.slave   bus
);

    // An all-zero LFSR would lock up, so a zero seed is promoted to 1
    localparam logic [PI_W-1:0] c_seed =
        (LFSR_SEED == '0) ? {{(PI_W-1){1'b0}}, 1'b1} : LFSR_SEED;
    localparam logic [3:0]  c_settle_last = 4'(SETTLE_CYCLES - 1);
    localparam logic [15:0] c_last_pat    = 16'(N_PATTERNS - 1);

    state_t            r_state;
    logic [PI_W-1:0]   r_lfsr;
    logic [15:0]       r_pat_count;
    logic [3:0]        r_settle_cnt;

    logic              w_start_ok;
    logic              w_misr_clear;
    logic              w_misr_en;
    logic [SIG_W-1:0]  w_signature;

    assign w_start_ok   = bus.start && (r_state == ST_IDLE || r_state == ST_DONE);
    // Clearing on acceptance makes the signature read 0 already in the SEED cycle
    assign w_misr_clear = w_start_ok || (r_state == ST_SEED);
    assign w_misr_en    = (r_state == ST_CAPTURE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_lfsr       <= c_seed;
            r_pat_count  <= '0;
            r_settle_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        r_state      <= ST_SEED;
                        r_lfsr       <= c_seed;
                        r_pat_count  <= '0;
                        r_settle_cnt <= '0;
                    end
                end
                ST_SEED: begin
                    r_state      <= ST_APPLY;
                    r_lfsr       <= c_seed;
                    r_pat_count  <= '0;
                    r_settle_cnt <= '0;
                end
                ST_APPLY: begin
                    if (r_settle_cnt == c_settle_last) begin
                        r_settle_cnt <= '0;
                        r_state      <= ST_CAPTURE;
                    end else begin
                        r_settle_cnt <= r_settle_cnt + 4'd1;
                    end
                end
                ST_CAPTURE: begin
                    r_lfsr      <= lfsr_next(r_lfsr);
                    r_pat_count <= r_pat_count + 16'd1;
                    r_state     <= (r_pat_count == c_last_pat) ? ST_DONE : ST_APPLY;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    c432_bist_misr u_misr (
        .clk       (clk),
        .rst       (rst),
        .clear     (w_misr_clear),
        .enable    (w_misr_en),
        .data      (bus.cut_po),
        .signature (w_signature)
    );

    assign bus.busy      = (r_state == ST_SEED) || (r_state == ST_APPLY) ||
                           (r_state == ST_CAPTURE);
    assign bus.done      = (r_state == ST_DONE);
    assign bus.pass      = (r_state == ST_DONE) && (w_signature == GOLDEN_SIG);
    assign bus.signature = w_signature;
    assign bus.pat_count = r_pat_count;
    // Only drive the CUT while a pattern is live
    assign bus.cut_pi    = (r_state == ST_APPLY || r_state == ST_CAPTURE) ? r_lfsr : '0;

endmodule

`default_nettype wire

// File: tb/tb_c432_bist_ctrl.sv
// ============================================================================
//  Module   : tb_c432_bist_ctrl
//  Brief    : Directed self-checking bench for c432_bist_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_c432_bist_ctrl;

    logic clk = 1'b0;
    logic rst0, rst1, rst2, rst3, rst4;
    int   n_checks = 0;
    int   n_errors = 0;
    int   edges;

    always #5 clk = ~clk;

    c432_bist_if bus0 ();
    c432_bist_if bus1 ();
    c432_bist_if bus2 ();
    c432_bist_if bus3 ();
    c432_bist_if bus4 ();

    c432_bist_ctrl #(.N_PATTERNS(3), .SETTLE_CYCLES(1), .LFSR_SEED(36'h1),
                     .GOLDEN_SIG(16'h0000))
        u_dut0 (.clk(clk), .rst(rst0), .bus(bus0));
    c432_bist_ctrl #(.N_PATTERNS(2), .SETTLE_CYCLES(1), .LFSR_SEED(36'h1),
                     .GOLDEN_SIG(16'h0003))
        u_dut1 (.clk(clk), .rst(rst1), .bus(bus1));
    c432_bist_ctrl #(.N_PATTERNS(4), .SETTLE_CYCLES(3), .LFSR_SEED(36'h0),
                     .GOLDEN_SIG(16'h0000))
        u_dut2 (.clk(clk), .rst(rst2), .bus(bus2));
    c432_bist_ctrl #(.N_PATTERNS(2), .SETTLE_CYCLES(1), .LFSR_SEED(36'h1),
                     .GOLDEN_SIG(16'h0000))
        u_dut3 (.clk(clk), .rst(rst3), .bus(bus3));
    c432_bist_ctrl #(.N_PATTERNS(11), .SETTLE_CYCLES(2), .LFSR_SEED(36'h8_0100_0001),
                     .GOLDEN_SIG(16'hEFE1))
        u_dut4 (.clk(clk), .rst(rst4), .bus(bus4));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [35:0] exp_pat [3];

    initial begin
        exp_pat[0] = 36'h1;
        exp_pat[1] = 36'h2;
        exp_pat[2] = 36'h4;

        {rst0, rst1, rst2, rst3, rst4} = '1;
        bus0.start = 0; bus1.start = 0; bus2.start = 0; bus3.start = 0; bus4.start = 0;
        bus0.cut_po = 7'h00; bus1.cut_po = 7'h01; bus2.cut_po = 7'h55;
        bus3.cut_po = 7'h01; bus4.cut_po = 7'h40;
        tick();
        tick();
        {rst0, rst1, rst2, rst3, rst4} = '0;

        // Reset state and quiet idle
        check("rst_pass", 64'(bus0.pass), 64'h0);
        check("rst_patcnt", 64'(bus0.pat_count), 64'h0);
        for (int i = 0; i < 10; i++) begin
            check("idle_busy", 64'(bus0.busy), 64'h0);
            check("idle_done", 64'(bus0.done), 64'h0);
            check("idle_cutpi", 64'(bus0.cut_pi), 64'h0);
            check("idle_sig", 64'(bus0.signature), 64'h0);
            tick();
        end

        // Pattern sequence: 1, 2, 4 with one settle cycle
        bus0.start = 1;
        tick();
        bus0.start = 0;
        check("seed_busy", 64'(bus0.busy), 64'h1);
        check("seed_cutpi", 64'(bus0.cut_pi), 64'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("apply_cutpi", 64'(bus0.cut_pi), 64'(exp_pat[k]));
            tick();
            check("capture_cutpi", 64'(bus0.cut_pi), 64'(exp_pat[k]));
        end
        tick();
        check("seq_done", 64'(bus0.done), 64'h1);
        check("seq_done_cutpi", 64'(bus0.cut_pi), 64'h0);
        check("seq_patcnt", 64'(bus0.pat_count), 64'd3);

        // Signature and exact done timing
        bus1.start = 1;
        tick();
        bus1.start = 0;
        for (int e = 1; e <= 5; e++) begin
            tick();
            if (e == 3) begin
                check("sig_first", 64'(bus1.signature), 64'h0001);
                check("patcnt_first", 64'(bus1.pat_count), 64'd1);
            end
            if (e == 4) check("done_early", 64'(bus1.done), 64'h0);
        end
        check("done_t6", 64'(bus1.done), 64'h1);
        check("pass_t6", 64'(bus1.pass), 64'h1);
        check("sig_final", 64'(bus1.signature), 64'h0003);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("done_hold", 64'(bus1.done), 64'h1);
            check("pass_hold", 64'(bus1.pass), 64'h1);
        end

        // Restart from DONE gives the same signature
        bus1.start = 1;
        tick();
        bus1.start = 0;
        check("restart_busy", 64'(bus1.busy), 64'h1);
        check("restart_done", 64'(bus1.done), 64'h0);
        check("restart_pass", 64'(bus1.pass), 64'h0);
        check("restart_sig", 64'(bus1.signature), 64'h0);
        for (int e = 1; e <= 50; e++) begin
            tick();
            if (bus1.done) break;
        end
        check("rerun_done", 64'(bus1.done), 64'h1);
        check("rerun_sig", 64'(bus1.signature), 64'h0003);

        // Latency with SETTLE_CYCLES=3, zero seed, start pulses while busy
        bus2.start = 1;
        tick();
        bus2.start = 0;
        edges = 0;
        for (int e = 1; e <= 100; e++) begin
            tick();
            edges = e;
            if (e == 1) check("zero_seed_cutpi", 64'(bus2.cut_pi), 64'h1);
            bus2.start = (e >= 3 && e <= 5);
            if (bus2.done) break;
        end
        bus2.start = 0;
        check("latency_done", 64'(bus2.done), 64'h1);
        check("latency_t18", 64'(edges + 1), 64'd18);
        check("latency_patcnt", 64'(bus2.pat_count), 64'd4);
        check("latency_sig", 64'(bus2.signature), 64'h0303);

        // Signature mismatch, then reset in the second APPLY
        bus3.start = 1;
        tick();
        bus3.start = 0;
        for (int e = 1; e <= 50; e++) begin
            tick();
            if (bus3.done) break;
        end
        check("mis_done", 64'(bus3.done), 64'h1);
        check("mis_pass", 64'(bus3.pass), 64'h0);
        check("mis_sig", 64'(bus3.signature), 64'h0003);
        bus3.start = 1;
        tick();
        bus3.start = 0;
        tick();
        tick();
        tick();
        check("apply2_cutpi", 64'(bus3.cut_pi), 64'h2);
        rst3 = 1;
        tick();
        rst3 = 0;
        check("midrst_busy", 64'(bus3.busy), 64'h0);
        check("midrst_done", 64'(bus3.done), 64'h0);
        check("midrst_pass", 64'(bus3.pass), 64'h0);
        check("midrst_sig", 64'(bus3.signature), 64'h0);
        check("midrst_patcnt", 64'(bus3.pat_count), 64'h0);
        check("midrst_cutpi", 64'(bus3.cut_pi), 64'h0);
        rst3 = 1;
        bus3.start = 1;
        tick();
        rst3 = 0;
        bus3.start = 0;
        tick();
        check("rst_wins_busy", 64'(bus3.busy), 64'h0);

        // LFSR feedback tap and MISR polynomial feedback
        bus4.start = 1;
        tick();
        bus4.start = 0;
        tick();
        check("tap_pat0", 64'(bus4.cut_pi), 64'h8_0100_0001);
        tick();
        tick();
        tick();
        check("tap_pat1", 64'(bus4.cut_pi), 64'h0_0200_0002);
        for (int e = 1; e <= 100; e++) begin
            tick();
            if (bus4.done) break;
        end
        check("poly_done", 64'(bus4.done), 64'h1);
        check("poly_sig", 64'(bus4.signature), 64'hEFE1);
        check("poly_pass", 64'(bus4.pass), 64'h1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
